// File: rtl/soc_system_pio_pkg.sv
// Shared definitions for the soc_system PIO family: register map and edge-type encodings.
package soc_system_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_ANY  = 2;

endpackage

// File: rtl/soc_system_pio_sync.sv
// Parametrised multi-flop synchroniser with asynchronous active-high reset.
module soc_system_pio_sync #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage [STAGES];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < STAGES; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_q = r_stage[STAGES-1];

endmodule

// File: rtl/soc_system_pio_in_edge.sv
// Avalon-MM input PIO with synchronised level, sticky edge capture and maskable irq.
// Define PIO_IN_BITCLEAR_EN for write-1-to-clear EDGECAP; otherwise any write clears all bits.
module soc_system_pio_in_edge
  import soc_system_pio_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_TYPE   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [31:0]           readdata,
  output logic                  irq
);

  localparam logic [2:0] WARM = 3'(SYNC_STAGES + 1);

  logic [DATA_WIDTH-1:0] w_sync_q;
  logic [DATA_WIDTH-1:0] r_prev_q;
  logic [DATA_WIDTH-1:0] r_irqmask;
  logic [DATA_WIDTH-1:0] r_edgecap;
  logic [DATA_WIDTH-1:0] w_edges;
  logic [DATA_WIDTH-1:0] w_clr;
  logic [DATA_WIDTH-1:0] w_edgecap_d;
  logic [2:0]            r_warm;
  logic                  w_cap_en;
  logic                  w_wr;
  logic [31:0]           w_rdata;
  logic                  w_unused_wdata;

  soc_system_pio_sync #(
    .WIDTH  (DATA_WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (in_port),
    .o_q   (w_sync_q)
  );

  assign w_wr           = chipselect & ~write_n;
  assign w_cap_en       = (r_warm == WARM);
  assign w_unused_wdata = ^writedata;

  always_comb begin
    w_edges = w_sync_q & ~r_prev_q;
    case (EDGE_TYPE)
      EDGE_FALL: w_edges = ~w_sync_q & r_prev_q;
      EDGE_ANY:  w_edges = w_sync_q ^ r_prev_q;
      default:   w_edges = w_sync_q & ~r_prev_q;
    endcase
  end

  always_comb begin
    w_clr = '0;
    if (w_wr && (address == ADDR_EDGECAP)) begin
`ifdef PIO_IN_BITCLEAR_EN
      w_clr = writedata[DATA_WIDTH-1:0];
`else
      w_clr = '1;
`endif
    end
    // Set is OR-ed in after the clear so a same-cycle edge wins.
    w_edgecap_d = (r_edgecap & ~w_clr) | (w_cap_en ? w_edges : '0);
  end

  always_comb begin
    w_rdata = '0;
    case (address)
      ADDR_DATA:    w_rdata[DATA_WIDTH-1:0] = w_sync_q;
      ADDR_RSVD:    w_rdata = '0;
      ADDR_IRQMASK: w_rdata[DATA_WIDTH-1:0] = r_irqmask;
      ADDR_EDGECAP: w_rdata[DATA_WIDTH-1:0] = r_edgecap;
      default:      w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prev_q  <= '0;
      r_irqmask <= '0;
      r_edgecap <= '0;
      r_warm    <= '0;
      readdata  <= '0;
      irq       <= 1'b0;
    end else begin
      r_prev_q  <= w_sync_q;
      r_edgecap <= w_edgecap_d;
      readdata  <= w_rdata;
      irq       <= |(r_edgecap & r_irqmask);
      if (r_warm != WARM) begin
        r_warm <= r_warm + 3'd1;
      end
      if (w_wr && (address == ADDR_IRQMASK)) begin
        r_irqmask <= writedata[DATA_WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_soc_system_pio_in_edge.sv
// Scoreboard bench for soc_system_pio_in_edge (DATA_WIDTH=8, SYNC_STAGES=2, rising edges).
module tb_soc_system_pio_in_edge;

  typedef struct {
    string       name;
    logic [31:0] rd;
    logic        irq;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in_port;
  logic [31:0] readdata;
  logic        irq;

  logic        chk_req = 1'b0;
  exp_t        sq[$];
  exp_t        aq[$];
  event        async_ev;
  int          n_checks = 0;
  int          n_fail   = 0;

  soc_system_pio_in_edge #(
    .DATA_WIDTH  (8),
    .SYNC_STAGES (2),
    .EDGE_TYPE   (0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Clocked monitor: compares the readdata/irq produced by each issued transaction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (chk_req) begin
        @(negedge clk);
        if (sq.size() == 0) begin
          check("sq_underflow", 32'd1, 32'd0);
        end else begin
          e = sq.pop_front();
          check({e.name, "_rd"}, readdata, e.rd);
          check({e.name, "_irq"}, {31'd0, irq}, {31'd0, e.irq});
        end
      end
    end
  end

  // Unclocked monitor for asynchronous-reset effects.
  always begin
    exp_t e;
    @(async_ev);
    if (aq.size() == 0) begin
      check("aq_underflow", 32'd1, 32'd0);
    end else begin
      e = aq.pop_front();
      check({e.name, "_rd"}, readdata, e.rd);
      check({e.name, "_irq"}, {31'd0, irq}, {31'd0, e.irq});
    end
  end

  task automatic cyc(input logic [1:0] a, input logic we, input logic [31:0] wd,
                     input logic [31:0] erd, input logic eirq, input string nm);
    address    = a;
    chipselect = we;
    write_n    = ~we;
    writedata  = wd;
    sq.push_back('{nm, erd, eirq});
    chk_req = 1'b1;
    @(posedge clk);
    #1;
    chk_req    = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset      = 1'b1;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = 8'hA5;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    idle(5);

    // Level read, reserved, reset values; A5 high bits blocked by warm-up
    cyc(2'd0, 1'b0, 32'h0, 32'h0000_00A5, 1'b0, "data_a5");
    cyc(2'd1, 1'b0, 32'h0, 32'h0, 1'b0, "rsvd");
    cyc(2'd2, 1'b0, 32'h0, 32'h0, 1'b0, "mask_rst");
    cyc(2'd3, 1'b0, 32'h0, 32'h0, 1'b0, "cap_warm_a5");
    cyc(2'd2, 1'b1, 32'hFFFF_FF01, 32'h0, 1'b0, "mask_wr");
    cyc(2'd2, 1'b0, 32'h0, 32'h1, 1'b0, "mask_rd");

    // Falling edge on bit0 is ignored
    in_port = 8'hA4;
    for (int i = 0; i < 4; i++) cyc(2'd3, 1'b0, 32'h0, 32'h0, 1'b0, "fall_ignored");
    cyc(2'd0, 1'b0, 32'h0, 32'h0000_00A4, 1'b0, "data_a4");

    // Rising edge on bit0: cap at N+2, irq at N+3
    in_port = 8'hA5;
    cyc(2'd3, 1'b0, 32'h0, 32'h0, 1'b0, "rise_n0");
    cyc(2'd3, 1'b0, 32'h0, 32'h0, 1'b0, "rise_n1");
    cyc(2'd3, 1'b0, 32'h0, 32'h0, 1'b0, "rise_n2");
    cyc(2'd3, 1'b0, 32'h0, 32'h1, 1'b1, "rise_n3");

    // Bit1 rises -> EDGECAP=03, then clear with writedata=1
    in_port = 8'hA7;
    idle(4);
    cyc(2'd3, 1'b0, 32'h0, 32'h3, 1'b1, "cap_03");
    cyc(2'd3, 1'b1, 32'h1, 32'h3, 1'b1, "clr_edge");
`ifdef PIO_IN_BITCLEAR_EN
    cyc(2'd3, 1'b0, 32'h0, 32'h2, 1'b0, "clr_res");
    cyc(2'd3, 1'b1, 32'hFF, 32'h2, 1'b0, "clr_rest");
`else
    cyc(2'd3, 1'b0, 32'h0, 32'h0, 1'b0, "clr_res");
    cyc(2'd3, 1'b1, 32'h0, 32'h0, 1'b0, "clr_rest");
`endif
    cyc(2'd3, 1'b0, 32'h0, 32'h0, 1'b0, "clr_all");

    // Clear of bit0 in the same cycle its edge is captured: set wins
    in_port = 8'hA6;
    idle(4);
    in_port = 8'hA7;
    cyc(2'd3, 1'b0, 32'h0, 32'h0, 1'b0, "col_n0");
    cyc(2'd3, 1'b0, 32'h0, 32'h0, 1'b0, "col_n1");
    cyc(2'd3, 1'b1, 32'h1, 32'h0, 1'b0, "col_n2");
    cyc(2'd3, 1'b0, 32'h0, 32'h1, 1'b1, "col_n3");

    // Capture on every bit, then async reset between edges
    cyc(2'd2, 1'b1, 32'hFF, 32'h1, 1'b1, "mask_ff");
    in_port = 8'h00;
    idle(4);
    in_port = 8'hFF;
    idle(4);
    cyc(2'd3, 1'b0, 32'h0, 32'hFF, 1'b1, "cap_ff");
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    aq.push_back('{"async_rst", 32'h0, 1'b0});
    ->async_ev;
    #1;
    @(posedge clk);
    #1;
    reset = 1'b0;

    // FF held through reset release: no spurious capture
    idle(5);
    cyc(2'd2, 1'b0, 32'h0, 32'h0, 1'b0, "mask_after_rst");
    cyc(2'd3, 1'b0, 32'h0, 32'h0, 1'b0, "cap_warm_ff");
    cyc(2'd0, 1'b0, 32'h0, 32'h0000_00FF, 1'b0, "data_ff");
    cyc(2'd3, 1'b0, 32'h0, 32'h0, 1'b0, "cap_warm_ff2");

    idle(2);
    check("sq_drained", sq.size(), 32'd0);
    check("aq_drained", aq.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
